level_controller: RTL and testbench

Game-progress controller that produces the `curr_level` code consumed by `clock_divider`, closing the loop between player events and game speed. It counts hits and misses, keeps score and lives, and advances the level after a fixed number of hits. It also pauses play for a fixed number of game ticks after each level-up. It sits between the input/collision logic (hit/miss pulses) and `clock_divider`, whose divided `clock` output it samples back as the game tick.

---
 rtl/level_controller.sv | 191 +++++++++++++++++++
 tb/tb_level_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_controller.sv
// ----------------------------------------------------------------------------
// level_controller
//
// Game-progress controller. Counts hit/miss pulses, keeps score and lives,
// advances the level every HITS_PER_LEVEL hits and, after each level-up,
// pauses play for PAUSE_TICKS rising edges of the divided game tick before
// resuming. The current level feeds clock_divider, whose divided clock comes
// back in here as `tick`, which closes the speed loop.
//
// Parameters:
//   MAX_LEVEL       highest level (levels run 1..MAX_LEVEL, fits in 4 bits)
//   HITS_PER_LEVEL  hits needed to advance one level
//   START_LIVES     lives at game start (1..3)
//   PAUSE_TICKS     tick rising edges spent in LEVEL_UP
//   SCORE_W         score width (score saturates at 2^SCORE_W-1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active low
//   tick        in   divided game clock, sampled in the clk domain
//   start       in   one-cycle pulse: start / restart a game
//   hit         in   one-cycle pulse: player scored
//   miss        in   one-cycle pulse: player missed
//   curr_level  out  current level (to clock_divider)
//   score       out  accumulated score
//   lives       out  remaining lives
//   playing     out  high while in PLAY
//   level_up    out  one-cycle pulse per level increment
//   game_over   out  high while in GAME_OVER
// ----------------------------------------------------------------------------
module level_controller #(
  parameter int MAX_LEVEL      = 9,
  parameter int HITS_PER_LEVEL = 8,
  parameter int START_LIVES    = 3,
  parameter int PAUSE_TICKS    = 4,
  parameter int SCORE_W        = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic [3:0]         curr_level,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               playing,
  output logic               level_up,
  output logic               game_over
);

  // Counter widths hold the full terminal count so the counters can be
  // compared against the "last" value without wrap concerns.
  localparam int HIT_W   = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL + 1) : 1;
  localparam int PAUSE_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS + 1) : 1;

  localparam logic [HIT_W-1:0]   HITS_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);
  localparam logic [3:0]         LEVEL_MAX  = 4'(MAX_LEVEL);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_LEVEL_UP  = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t               state_q;
  logic                 tick_q;
  logic [HIT_W-1:0]     hit_cnt_q;
  logic [PAUSE_W-1:0]   pause_cnt_q;
  logic [3:0]           level_q;
  logic [SCORE_W-1:0]   score_q;
  logic [1:0]           lives_q;
  logic                 playing_q;
  logic                 level_up_q;
  logic                 game_over_q;

  // Combinational helpers feeding the state register.
  logic                 tick_rise_d;
  logic [SCORE_W:0]     score_sum_d;
  logic [SCORE_W-1:0]   score_sat_d;
  logic                 level_done_d;
  logic                 pause_done_d;

  // The tick is slow and comes from our own clock domain (a divided copy of
  // clk), so a single register is enough to find its rising edge.
  assign tick_rise_d = tick & ~tick_q;

  // One extra bit catches the carry out; on carry the score pins at full
  // scale instead of wrapping.
  assign score_sum_d  = {1'b0, score_q} + (SCORE_W + 1)'(level_q);
  assign score_sat_d  = score_sum_d[SCORE_W] ? SCORE_MAX : score_sum_d[SCORE_W-1:0];

  // True when the hit being accepted now is the last one of this level.
  assign level_done_d = (hit_cnt_q == HITS_LAST);

  // True when the tick rise being accepted now ends the pause.
  assign pause_done_d = (pause_cnt_q == PAUSE_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tick_q      <= 1'b0;
      hit_cnt_q   <= '0;
      pause_cnt_q <= '0;
      level_q     <= 4'd1;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      playing_q   <= 1'b0;
      level_up_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      tick_q     <= tick;
      level_up_q <= 1'b0;

      case (state_q)
        // IDLE and GAME_OVER behave the same way: everything is frozen
        // until start, which re-initialises the game and enters PLAY.
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            state_q     <= S_PLAY;
            hit_cnt_q   <= '0;
            pause_cnt_q <= '0;
            level_q     <= 4'd1;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end

        S_PLAY: begin
          // A miss takes precedence; a coincident hit is discarded.
          if (miss) begin
            if (lives_q > 2'd1) begin
              lives_q <= lives_q - 2'd1;
            end else begin
              lives_q     <= 2'd0;
              state_q     <= S_GAME_OVER;
              playing_q   <= 1'b0;
              game_over_q <= 1'b1;
            end
          end else if (hit) begin
            score_q <= score_sat_d;
            if (level_done_d) begin
              hit_cnt_q <= '0;
              // At the top level the hit counter still rolls over, but the
              // level holds and play continues without a pause.
              if (level_q < LEVEL_MAX) begin
                level_q     <= level_q + 4'd1;
                level_up_q  <= 1'b1;
                pause_cnt_q <= '0;
                state_q     <= S_LEVEL_UP;
                playing_q   <= 1'b0;
              end
            end else begin
              hit_cnt_q <= hit_cnt_q + 1'b1;
            end
          end
        end

        S_LEVEL_UP: begin
          if (tick_rise_d) begin
            pause_cnt_q <= pause_cnt_q + 1'b1;
            if (pause_done_d) begin
              state_q   <= S_PLAY;
              playing_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          playing_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign curr_level = level_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign playing    = playing_q;
  assign level_up   = level_up_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_level_controller.sv
// ----------------------------------------------------------------------------
// tb_level_controller
//
// Stimulus drives one input vector per clk cycle. After each rising edge the
// reference model (game rules written with plain integers) is advanced with
// the vector the DUT just sampled, and the expected outputs are pushed onto a
// queue. A separate monitor pops one entry on every falling edge and compares
// it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_level_controller;

  localparam int MAXL   = 9;
  localparam int HPL    = 4;
  localparam int LIVES0 = 3;
  localparam int PT     = 3;
  localparam int SW     = 8;
  localparam int SMAX   = (1 << SW) - 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          tick  = 1'b0;
  logic          start = 1'b0;
  logic          hit   = 1'b0;
  logic          miss  = 1'b0;
  logic [3:0]    curr_level;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic          playing;
  logic          level_up;
  logic          game_over;

  always #5 clk = ~clk;

  level_controller #(
    .MAX_LEVEL      (MAXL),
    .HITS_PER_LEVEL (HPL),
    .START_LIVES    (LIVES0),
    .PAUSE_TICKS    (PT),
    .SCORE_W        (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .curr_level (curr_level),
    .score      (score),
    .lives      (lives),
    .playing    (playing),
    .level_up   (level_up),
    .game_over  (game_over)
  );

  typedef struct packed {
    logic [3:0]    lvl;
    logic [SW-1:0] score;
    logic [1:0]    lives;
    logic          playing;
    logic          level_up;
    logic          game_over;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;

  // ---------------------------------------------------------------- model
  // Game phase: 0 idle, 1 play, 2 paused after level-up, 3 game over.
  int m_phase = 0;
  int m_level = 1;
  int m_score = 0;
  int m_lives = LIVES0;
  int m_hits  = 0;
  int m_ticks = 0;
  int m_prev  = 0;
  int m_pulse = 0;

  function void new_game();
    m_level = 1;
    m_score = 0;
    m_lives = LIVES0;
    m_hits  = 0;
    m_ticks = 0;
  endfunction

  function void model_step(input int r, input int s, input int h, input int m, input int t);
    int rise;
    m_pulse = 0;
    if (r == 0) begin
      new_game();
      m_phase = 0;
      m_prev  = 0;
      return;
    end
    rise   = (t == 1 && m_prev == 0) ? 1 : 0;
    m_prev = t;
    if (m_phase == 0 || m_phase == 3) begin
      if (s == 1) begin
        new_game();
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m == 1) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_phase = 3;
      end else if (h == 1) begin
        m_score = (m_score + m_level > SMAX) ? SMAX : m_score + m_level;
        m_hits  = m_hits + 1;
        if (m_hits == HPL) begin
          m_hits = 0;
          if (m_level < MAXL) begin
            m_level = m_level + 1;
            m_pulse = 1;
            m_ticks = 0;
            m_phase = 2;
          end
        end
      end
    end else begin
      if (rise == 1) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == PT) m_phase = 1;
      end
    end
  endfunction

  function exp_t model_out();
    exp_t e;
    e.lvl       = 4'(m_level);
    e.score     = SW'(m_score);
    e.lives     = 2'(m_lives);
    e.playing   = (m_phase == 1);
    e.level_up  = (m_pulse == 1);
    e.game_over = (m_phase == 3);
    return e;
  endfunction

  // ------------------------------------------------------------- stimulus
  task automatic step(input logic r, input logic s, input logic h, input logic m, input logic t);
    rst   = r;
    start = s;
    hit   = h;
    miss  = m;
    tick  = t;
    @(posedge clk);
    model_step(int'(r), int'(s), int'(h), int'(m), int'(t));
    exp_q.push_back(model_out());
    pushed++;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_hit();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_miss();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_start();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // n rising edges of tick, each held high for a cycle
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // -------------------------------------------------------------- monitor
  logic prev_go = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {curr_level, score, lives, playing, level_up, game_over};
      popped++;
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL outputs @%0t: got lvl=%0d score=%0d lives=%0d play=%b lvlup=%b gover=%b, want lvl=%0d score=%0d lives=%0d play=%b lvlup=%b gover=%b",
                 $time, got.lvl, got.score, got.lives, got.playing, got.level_up, got.game_over,
                 e.lvl, e.score, e.lives, e.playing, e.level_up, e.game_over);
      end
      if (e.level_up)
        $display("txn level_up: level=%0d score=%0d", e.lvl, e.score);
      if (e.game_over && !prev_go)
        $display("txn game_over: level=%0d score=%0d", e.lvl, e.score);
      prev_go = e.game_over;
    end
  end

  // ----------------------------------------------------------------- main
  initial begin
    logic t_cur;
    logic r_v, s_v, h_v, m_v;

    // Reset held for three cycles, then hit/miss while idle are ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_hit();
    do_miss();
    ticks(2);

    // Level advance, hits ignored during the pause, then resume.
    do_start();
    for (int i = 0; i < HPL; i++) do_hit();
    do_hit();
    do_miss();
    do_start();
    ticks(PT);
    idle(2);
    do_hit();

    // Lives to zero, then restart.
    do_miss();
    do_miss();
    do_miss();
    idle(2);
    do_hit();
    do_start();

    // Simultaneous hit and miss on the last life.
    do_miss();
    do_miss();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Climb to the top level and saturate the score.
    do_start();
    for (int l = 1; l < MAXL; l++) begin
      for (int i = 0; i < HPL; i++) do_hit();
      ticks(PT);
    end
    for (int i = 0; i < 3 * HPL + 4; i++) do_hit();

    // Reset in the middle of a pause; ticks do nothing afterwards.
    do_start();
    for (int i = 0; i < HPL; i++) do_hit();
    ticks(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(PT + 1);
    do_hit();
    do_start();

    // Randomised play.
    t_cur = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      r_v = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      s_v = ($urandom_range(0, 99) < 2);
      h_v = ($urandom_range(0, 99) < 40);
      m_v = ($urandom_range(0, 999) < 12);
      if ($urandom_range(0, 3) == 0) t_cur = ~t_cur;
      step(r_v, s_v, h_v, m_v, t_cur);
    end

    // Drain the scoreboard (bounded), then confirm every entry was seen.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (popped != pushed || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: popped=%0d pushed=%0d left=%0d", popped, pushed, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
